// File: rtl/timer_pkg.sv
// Shared constants and types for the stopwatch/timer count chain.
package timer_pkg;

    localparam int unsigned CS_MAX  = 99;
    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;

    localparam int unsigned CS_W  = 7;
    localparam int unsigned SEC_W = 6;
    localparam int unsigned MIN_W = 6;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

endpackage

// File: rtl/wrap_counter.sv
// One time field: counts 0..MAX up or down with carry/borrow out, saturating load, sync clear.
module wrap_counter
    import timer_pkg::*;
#(
    parameter int unsigned MAX = 9,
    parameter int unsigned W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] ld_val,
    input  logic         step,
    input  dir_e         dir,
    output logic [W-1:0] value,
    output logic         carry
);

    localparam logic [W-1:0] LIM = W'(MAX);

    logic [W-1:0] value_q, value_d;
    logic         at_limit;

    assign at_limit = (dir == DIR_UP) ? (value_q == LIM) : (value_q == '0);
    // Carry (up) or borrow (down) fires combinationally on the same edge as this field's wrap.
    assign carry    = step && at_limit;
    assign value    = value_q;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (load) begin
            value_d = (ld_val > LIM) ? LIM : ld_val;
        end else if (step) begin
            if (dir == DIR_UP) begin
                value_d = at_limit ? '0 : value_q + W'(1);
            end else begin
                value_d = at_limit ? LIM : value_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/timer_counter_chain.sv
// HH:MM:SS.cc up/down count chain with prescaler, preset load, done/ovf strobes.
// Optional lap capture is built when LAP_CAPTURE_EN is defined.
module timer_counter_chain
    import timer_pkg::*;
#(
    parameter int unsigned DIV_MAX = 49999,
    parameter int unsigned HR_MAX  = 99,
    localparam int unsigned HW     = $clog2(HR_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en,
    input  logic             cnt_clr,
    input  logic             load,
    input  logic             dir,
    input  logic [HW-1:0]    ld_h,
    input  logic [MIN_W-1:0] ld_m,
    input  logic [SEC_W-1:0] ld_s,
    input  logic [CS_W-1:0]  ld_t,
    output logic [HW-1:0]    hcnt,
    output logic [MIN_W-1:0] mcnt,
    output logic [SEC_W-1:0] scnt,
    output logic [CS_W-1:0]  tcnt,
    output logic             tick,
    output logic             ovf,
    output logic             done,
    input  logic             lap_req,
    output logic [HW-1:0]    lap_h,
    output logic [MIN_W-1:0] lap_m,
    output logic [SEC_W-1:0] lap_s,
    output logic [CS_W-1:0]  lap_t,
    output logic             lap_vld
);

    localparam int unsigned DW = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;

    dir_e          dir_sel;
    logic [DW-1:0] div_q, div_d;
    logic          tick_q, ovf_q, done_q, done_d;
    logic          run, period_end, all_zero, step_t;
    logic          clr_f, load_f;
    logic          t_carry, s_carry, m_carry, h_carry;

    assign dir_sel    = dir_e'(dir);
    assign run        = cnt_en && !done_q;
    assign period_end = run && (div_q == DW'(DIV_MAX));
    assign clr_f      = !cnt_en && cnt_clr;
    assign load_f     = !cnt_en && !cnt_clr && load;
    assign all_zero   = (tcnt == '0) && (scnt == '0) && (mcnt == '0) && (hcnt == '0);
    // A down-count tick at 00:00:00.00 only latches done; fields never wrap from zero.
    assign step_t     = period_end && !((dir_sel == DIR_DN) && all_zero);

    always_comb begin
        div_d  = div_q;
        done_d = done_q;
        if (cnt_en) begin
            if (run) begin
                div_d = period_end ? '0 : div_q + DW'(1);
            end
            if (period_end && (dir_sel == DIR_DN) && all_zero) begin
                done_d = 1'b1;
            end
        end else if (clr_f || load_f) begin
            div_d  = '0;
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= period_end;
            ovf_q  <= (dir_sel == DIR_UP) && h_carry;
            done_q <= done_d;
        end
    end

    assign tick = tick_q;
    assign ovf  = ovf_q;
    assign done = done_q;

    wrap_counter #(.MAX(CS_MAX), .W(CS_W)) u_t (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_f),
        .load   (load_f),
        .ld_val (ld_t),
        .step   (step_t),
        .dir    (dir_sel),
        .value  (tcnt),
        .carry  (t_carry)
    );

    wrap_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_s (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_f),
        .load   (load_f),
        .ld_val (ld_s),
        .step   (t_carry),
        .dir    (dir_sel),
        .value  (scnt),
        .carry  (s_carry)
    );

    wrap_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_m (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_f),
        .load   (load_f),
        .ld_val (ld_m),
        .step   (s_carry),
        .dir    (dir_sel),
        .value  (mcnt),
        .carry  (m_carry)
    );

    wrap_counter #(.MAX(HR_MAX), .W(HW)) u_h (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_f),
        .load   (load_f),
        .ld_val (ld_h),
        .step   (m_carry),
        .dir    (dir_sel),
        .value  (hcnt),
        .carry  (h_carry)
    );

`ifdef LAP_CAPTURE_EN
    logic [HW-1:0]    lap_h_q;
    logic [MIN_W-1:0] lap_m_q;
    logic [SEC_W-1:0] lap_s_q;
    logic [CS_W-1:0]  lap_t_q;
    logic             lap_vld_q;

    // Samples the registered fields, so a capture coincident with a tick sees the pre-tick value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_h_q   <= '0;
            lap_m_q   <= '0;
            lap_s_q   <= '0;
            lap_t_q   <= '0;
            lap_vld_q <= 1'b0;
        end else begin
            lap_vld_q <= lap_req;
            if (lap_req) begin
                lap_h_q <= hcnt;
                lap_m_q <= mcnt;
                lap_s_q <= scnt;
                lap_t_q <= tcnt;
            end
        end
    end

    assign lap_h   = lap_h_q;
    assign lap_m   = lap_m_q;
    assign lap_s   = lap_s_q;
    assign lap_t   = lap_t_q;
    assign lap_vld = lap_vld_q;
`else
    logic unused_lap_req;
    assign unused_lap_req = lap_req;

    assign lap_h   = '0;
    assign lap_m   = '0;
    assign lap_s   = '0;
    assign lap_t   = '0;
    assign lap_vld = 1'b0;
`endif

endmodule

// File: tb/tb_timer_counter_chain.sv
// Directed bench for timer_counter_chain with DIV_MAX=4 (one tick every 5 clocks), HR_MAX=99.
module tb_timer_counter_chain;

    localparam int unsigned HW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cnt_en = 1'b0, cnt_clr = 1'b0, load = 1'b0, dir = 1'b0, lap_req = 1'b0;
    logic [HW-1:0] ld_h = '0;
    logic [5:0]    ld_m = '0, ld_s = '0;
    logic [6:0]    ld_t = '0;
    logic [HW-1:0] hcnt, lap_h;
    logic [5:0]    mcnt, scnt, lap_m, lap_s;
    logic [6:0]    tcnt, lap_t;
    logic          tick, ovf, done, lap_vld;

    int tests = 0;
    int fails = 0;

    timer_counter_chain #(.DIV_MAX(4), .HR_MAX(99)) dut (
        .clk     (clk),
        .rst     (rst),
        .cnt_en  (cnt_en),
        .cnt_clr (cnt_clr),
        .load    (load),
        .dir     (dir),
        .ld_h    (ld_h),
        .ld_m    (ld_m),
        .ld_s    (ld_s),
        .ld_t    (ld_t),
        .hcnt    (hcnt),
        .mcnt    (mcnt),
        .scnt    (scnt),
        .tcnt    (tcnt),
        .tick    (tick),
        .ovf     (ovf),
        .done    (done),
        .lap_req (lap_req),
        .lap_h   (lap_h),
        .lap_m   (lap_m),
        .lap_s   (lap_s),
        .lap_t   (lap_t),
        .lap_vld (lap_vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s,
                              input int t);
        check({tag, ".h"}, 32'(hcnt), 32'(h));
        check({tag, ".m"}, 32'(mcnt), 32'(m));
        check({tag, ".s"}, 32'(scnt), 32'(s));
        check({tag, ".t"}, 32'(tcnt), 32'(t));
    endtask

    // Advance n clock edges; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preset(input int h, input int m, input int s, input int t);
        cnt_en = 1'b0;
        ld_h = HW'(h); ld_m = 6'(m); ld_s = 6'(s); ld_t = 7'(t);
        load = 1'b1;
        cycles(1);
        load = 1'b0;
    endtask

    task automatic clear();
        cnt_en  = 1'b0;
        cnt_clr = 1'b1;
        cycles(1);
        cnt_clr = 1'b0;
    endtask

    initial begin
        // 1: reset state, then 500 clocks of up-count = 100 ticks = 00:00:01.00
        #2;
        check_time("rst", 0, 0, 0, 0);
        check("rst.tick", 32'(tick), 0);
        check("rst.ovf", 32'(ovf), 0);
        check("rst.done", 32'(done), 0);
        check("rst.lap_vld", 32'(lap_vld), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        dir = 1'b0;
        cnt_en = 1'b1;
        for (int i = 0; i < 500; i++) begin
            cycles(1);
            check("up.tick", 32'(tick), 32'(i % 5 == 4));
            check("up.ovf", 32'(ovf), 0);
            check("up.done", 32'(done), 0);
        end
        check_time("up500", 0, 0, 1, 0);

        // 2: wrap from the top of the range gives one ovf pulse
        preset(99, 59, 59, 99);
        check_time("ld_max", 99, 59, 59, 99);
        cnt_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            check("wrap.ovf", 32'(ovf), 32'(i == 4));
            if (i == 4) check_time("wrap", 0, 0, 0, 0);
        end
        check("wrap.done", 32'(done), 0);

        // 3: count down 1.00 s; done latches on the tick taken at zero, then everything freezes
        dir = 1'b1;
        preset(0, 0, 1, 0);
        cnt_en = 1'b1;
        cycles(5);
        check_time("dn1", 0, 0, 0, 99);
        cycles(495);
        check_time("dn100", 0, 0, 0, 0);
        check("dn100.done", 32'(done), 0);
        cycles(5);
        check("dn101.done", 32'(done), 1);
        check_time("dn101", 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            cycles(1);
            check("frozen.tick", 32'(tick), 0);
        end
        check_time("frozen", 0, 0, 0, 0);
        check("frozen.done", 32'(done), 1);

        // 4: pause holds state and divider phase; clr ignored while running
        clear();
        check("clr.done", 32'(done), 0);
        check_time("clr", 0, 0, 0, 0);
        dir = 1'b0;
        cnt_en = 1'b1;
        cycles(185);
        check_time("t37", 0, 0, 0, 37);
        cnt_en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cycles(1);
            check("pause.tick", 32'(tick), 0);
        end
        check_time("pause", 0, 0, 0, 37);
        cnt_en = 1'b1;
        cnt_clr = 1'b1;
        cycles(5);
        check_time("clr_ign", 0, 0, 0, 38);
        cnt_clr = 1'b0;
        cycles(2);
        cnt_en = 1'b0;
        cycles(10);
        cnt_en = 1'b1;
        cycles(2);
        check_time("midper", 0, 0, 0, 38);
        cycles(1);
        check_time("resume", 0, 0, 0, 39);
        clear();
        check_time("clr2", 0, 0, 0, 0);

        // 5: saturating load also clears done
        dir = 1'b1;
        cnt_en = 1'b1;
        cycles(5);
        check("dn0.done", 32'(done), 1);
        check_time("dn0", 0, 0, 0, 0);
        preset(120, 60, 63, 127);
        check_time("sat", 99, 59, 59, 99);
        check("sat.done", 32'(done), 0);

        // 6: lap capture while running at t=37
        clear();
        dir = 1'b0;
        cnt_en = 1'b1;
        cycles(185);
        lap_req = 1'b1;
        cycles(1);
        lap_req = 1'b0;
`ifdef LAP_CAPTURE_EN
        check("lap.t", 32'(lap_t), 37);
        check("lap.s", 32'(lap_s), 0);
        check("lap.vld", 32'(lap_vld), 1);
        cycles(1);
        check("lap.vld_off", 32'(lap_vld), 0);
        cycles(3);
        check_time("lap_run", 0, 0, 0, 38);
`else
        check("nolap.t", 32'(lap_t), 0);
        check("nolap.vld", 32'(lap_vld), 0);
        cycles(4);
        check_time("nolap_run", 0, 0, 0, 38);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
